// File: rtl/uart_img_pkg.sv
// uart_img_pkg: shared constants and state encoding for the UART image frame loader.
package uart_img_pkg;
    localparam int         IMG_BYTES   = 784;
    localparam int         TIMEOUT_CYC = 21700;
    localparam logic [7:0] HDR0        = 8'hAA;
    localparam logic [7:0] HDR1        = 8'h55;
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, READY} state_t;
endpackage

// File: rtl/byte_timeout.sv
// byte_timeout: inter-byte idle watchdog for an in-progress frame.
//   sys_clk/sys_rst_n : clock, async active-low reset
//   clear             : restart the idle count (a byte arrived)
//   enable            : count only while a frame is in progress, else hold at 0
//   expired           : one-cycle pulse; registered downstream so the error lands
//                       exactly TIMEOUT_CYC cycles after the last byte
module byte_timeout
    import uart_img_pkg::*;
#(
    parameter int TIMEOUT_CYC = uart_img_pkg::TIMEOUT_CYC
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] r_cnt;
    // The count is 0 in the cycle after the byte and the consumer adds one
    // register stage, hence the T-2 compare.
    assign expired = enable && !clear && (r_cnt == CW'(TIMEOUT_CYC - 2));
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_cnt <= '0;
        else if (clear || !enable || expired)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_img_loader.sv
// uart_img_loader: assembles a header-framed, checksummed image from a UART byte stream.
//   sys_clk/sys_rst_n      : clock, async active-low reset
//   rx_byte/rx_valid       : received byte and its one-cycle strobe
//   img_done               : inference engine releases the buffer
//   buf_we/addr/wdata      : image buffer write port
//   img_ready              : buffer holds a verified image
//   busy                   : frame in progress (HDR, DATA, CSUM)
//   frame_err/rx_overrun   : one-cycle error pulses
module uart_img_loader
    import uart_img_pkg::*;
#(
    parameter int         IMG_BYTES   = uart_img_pkg::IMG_BYTES,
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] HDR0        = uart_img_pkg::HDR0,
    parameter logic [7:0] HDR1        = uart_img_pkg::HDR1,
    parameter int         TIMEOUT_CYC = uart_img_pkg::TIMEOUT_CYC
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              img_done,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              img_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              rx_overrun
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [7:0]        r_sum;
    logic              w_active;
    logic              w_expired;

    assign w_active = (r_state == HDR) || (r_state == DATA) || (r_state == CSUM);

    byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (rx_valid),
        .enable    (w_active),
        .expired   (w_expired)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sum      <= '0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= '0;
            img_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            buf_we     <= 1'b0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
            // expired is never raised in a cycle carrying a byte, so it cannot
            // collide with the byte handling below.
            if (w_expired) begin
                r_state   <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: if (rx_valid && rx_byte == HDR0) begin
                        r_state <= HDR;
                        busy    <= 1'b1;
                    end
                    HDR: if (rx_valid) begin
                        if (rx_byte == HDR1) begin
                            r_cnt   <= '0;
                            r_sum   <= '0;
                            r_state <= DATA;
                        end else if (rx_byte != HDR0) begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    DATA: if (rx_valid) begin
                        buf_we    <= 1'b1;
                        buf_addr  <= r_cnt;
                        buf_wdata <= rx_byte;
                        r_sum     <= r_sum + rx_byte;
                        r_cnt     <= r_cnt + 1'b1;
                        if (r_cnt == ADDR_W'(IMG_BYTES - 1))
                            r_state <= CSUM;
                    end
                    CSUM: if (rx_valid) begin
                        busy <= 1'b0;
                        if (rx_byte == r_sum) begin
                            r_state   <= READY;
                            img_ready <= 1'b1;
                        end else begin
                            r_state   <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                    READY: begin
                        // No backpressure exists, so bytes arriving here are lost.
                        rx_overrun <= rx_valid;
                        if (img_done) begin
                            r_state   <= IDLE;
                            img_ready <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_img_loader.md
# uart_img_loader

Frame assembler directly downstream of the UART receiver in the MNIST inference path. Consumes the received byte stream at 460800 baud with a 100 MHz `sys_clk` (one byte per 2170 clocks). Locates a two-byte header, writes 784 pixel bytes into the image buffer RAM and verifies an 8-bit additive checksum. Presents a validated image to the inference engine with a ready/done handshake.

## Interface
- `IMG_BYTES`, 784: pixel bytes per frame (28×28).
- `ADDR_W`, 10: buffer address width; must satisfy 2^ADDR_W ≥ IMG_BYTES.
- `HDR0`, 8'hAA: first header byte.
- `HDR1`, 8'h55: second header byte.
- `TIMEOUT_CYC`, 21700: maximum idle cycles between bytes inside a frame (10 byte times).

- `sys_clk` in 1: system clock, 100 MHz, single clock domain.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `rx_byte` in 8: byte from UART RX, valid only when `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `img_done` in 1: one-cycle pulse from the inference engine; buffer released.
- `buf_we` out 1: image buffer write enable.
- `buf_addr` out ADDR_W: image buffer write address.
- `buf_wdata` out 8: image buffer write data.
- `img_ready` out 1: level; buffer holds a checksum-verified image.
- `busy` out 1: high in HDR, DATA and CSUM.
- `frame_err` out 1: one-cycle pulse on checksum mismatch or timeout.
- `rx_overrun` out 1: one-cycle pulse when a byte is dropped in READY.

## Operation
- States: IDLE, HDR, DATA, CSUM, READY. Reset enters IDLE.
- **IDLE:** on `rx_byte`==HDR0, go to HDR. All other bytes are ignored.
- **HDR:**
  - `rx_byte`==HDR1: clear the address counter and the sum, then go to DATA.
  - `rx_byte`==HDR0: stay in HDR (resync).
  - Any other byte: go to IDLE.
- **DATA:** each byte is written to `buf_addr`=count and added to the sum. The sum is 8 bits and wraps mod 256. After byte IMG_BYTES-1, go to CSUM.
- **CSUM:**
  - Next byte equals the sum: go to READY.
  - Otherwise: pulse `frame_err` and go to IDLE. `img_ready` is never asserted for this frame.
- **READY:**
  - `img_ready`=1.
  - Every `rx_valid` pulses `rx_overrun`. The byte is discarded and no `buf_we` is issued.
  - `img_done` returns the block to IDLE.
- **Timeout:**
  - The counter clears on every `rx_valid` and increments in HDR, DATA and CSUM.
  - At TIMEOUT_CYC idle cycles: pulse `frame_err` and go to IDLE.
  - In IDLE and READY the counter is held at 0.
- `img_done` outside READY is ignored.
- `rx_valid` and `img_done` in the same cycle in READY: the byte is dropped with an `rx_overrun` pulse, and the block goes to IDLE.
- Partially written buffer contents after an error are not cleared. Validity is signalled only by `img_ready`.

## Timing
- Reset values: `buf_we`=0, `buf_addr`=0, `buf_wdata`=0, `img_ready`=0, `busy`=0, `frame_err`=0, `rx_overrun`=0. State, counters and sum are all 0.
- All outputs are registered.
- `buf_we`, `buf_addr` and `buf_wdata` are valid the cycle after the corresponding `rx_valid`. `buf_we` is high for exactly one cycle.
- `img_ready` rises 1 cycle after the checksum byte's `rx_valid`. It falls 1 cycle after `img_done`.
- `frame_err` on mismatch: 1 cycle after the checksum byte's `rx_valid`.
- `frame_err` on timeout: exactly TIMEOUT_CYC cycles after the last `rx_valid` cycle.
- `rx_overrun`: 1 cycle after the offending `rx_valid`.
- Reset asserted mid-frame: outputs go to reset values immediately and asynchronously. After release, the block is in IDLE and waits for a fresh header.
- Throughput: accepts `rx_valid` on any cycle, including back-to-back. There is no backpressure to the UART.

## Structure
- Package `uart_img_pkg` holds:
  - header constants HDR0 and HDR1;
  - IMG_BYTES and default TIMEOUT_CYC;
  - the state enum (IDLE, HDR, DATA, CSUM, READY).
- Sub-module `byte_timeout`:
  - inputs: `clear` (=`rx_valid`), `enable`;
  - output: one-cycle `expired` pulse at TIMEOUT_CYC.
- The FSM, address counter and checksum stay in `uart_img_loader`.

## Test plan
- **Valid frame:** AA 55, then pixels i[7:0] for i=0..783, then checksum F8.
  - Expect 784 `buf_we` pulses with addr=data-index.
  - `img_ready` rises 1 cycle after F8. No `frame_err`.
  - `img_done` clears `img_ready` 1 cycle later.
- **Bad checksum:** same frame ending in F7.
  - `frame_err` pulses once; `img_ready` stays 0.
  - A following valid frame is accepted.
- **Header resync:** bytes 12 AA AA 55, then a valid frame. Frame accepted, first write at addr 0.
- **Timeout:** AA 55 plus 100 pixels, then silence.
  - `frame_err` pulses exactly 21700 cycles after the last `rx_valid`; state returns to IDLE.
  - A subsequent valid frame is accepted.
- **Overrun:** two bytes sent while `img_ready`=1.
  - Two `rx_overrun` pulses, no `buf_we`, `img_ready` stays 1.
  - `img_done` coincident with the second byte: that byte is still dropped.
- **Reset mid-frame:** assert `sys_rst_n`=0 after 300 pixels.
  - All outputs go to 0 immediately.
  - After release, a full valid frame completes normally.
